led_chain_router: RTL and testbench

- Controller that sequences the smart-LED stream mux. It decodes the incoming WS2812-style serial line by pulse-width timing and counts 24-bit LED words.
- It routes the stream onto one of three output strings: the first LEDS_PER_CH LEDs go to out0, the next LEDS_PER_CH to out1, the next LEDS_PER_CH to out2.
- A long low level (latch/reset gap) restarts routing at out0.
- A long high level enters test mode, in which the stream is broadcast to all outputs.

---
 rtl/led_chain_router.sv | 164 ++++++++++++++++
 tb/tb_led_chain_router.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_chain_router.sv
// +----------------------------------------------------------------------------+
// | led_chain_router                                                           |
// | Splits a WS2812-style LED stream across three strings by LED-word count.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module led_chain_router #(
  parameter int BIT_THRESH   = 30,
  parameter int RESET_CYCLES = 2500,
  parameter int TEST_CYCLES  = 5000,
  parameter int LEDS_PER_CH  = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data,
  input  logic       exclusive,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       testmode,
  output logic [1:0] chan,
  output logic       frame_active
);

  localparam int LED_W = (LEDS_PER_CH > 1) ? $clog2(LEDS_PER_CH) : 1;

  localparam logic [CNT_W-1:0] C_THRESH   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] C_RESET    = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] C_TEST     = CNT_W'(TEST_CYCLES);
  localparam logic [4:0]       C_LAST_BIT = 5'd23;
  localparam logic [LED_W-1:0] C_LAST_LED = LED_W'(LEDS_PER_CH - 1);
  localparam logic [1:0]       C_CHAN_END = 2'd3;

  logic             sync1_q, sync1_d;
  logic             data_s_q, data_s_d;
  logic             data_p_q, data_p_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;
  logic [1:0]       chan_q, chan_d;
  logic             frame_active_q, frame_active_d;
  logic             testmode_q, testmode_d;
  logic [2:0]       out_q, out_d;

  logic rise;
  logic fall;
  logic frame_reset;
  logic broadcast;
  logic bit_val_unused;

  assign rise = data_s_q & ~data_p_q;
  assign fall = ~data_s_q & data_p_q;

  // Decoded bit value: routing depends only on pulse timing, so it is not retained.
  assign bit_val_unused = (hi_cnt_q > C_THRESH);

  always_comb begin
    sync1_d        = data;
    data_s_d       = sync1_q;
    data_p_d       = data_s_q;
    hi_cnt_d       = hi_cnt_q;
    lo_cnt_d       = lo_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    led_cnt_d      = led_cnt_q;
    chan_d         = chan_q;
    frame_active_d = frame_active_q;
    testmode_d     = testmode_q;
    frame_reset    = 1'b0;
    broadcast      = 1'b0;
    out_d          = '0;

    if (rise) begin
      hi_cnt_d = '0;
    end else if (data_s_q && (hi_cnt_q < C_TEST)) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end

    if (fall) begin
      lo_cnt_d = '0;
    end else if (!data_s_q && (lo_cnt_q < C_RESET)) begin
      lo_cnt_d = lo_cnt_q + 1'b1;
    end

    // Both thresholds act only on the single cycle the counter first reaches them.
    if ((hi_cnt_d == C_TEST) && (hi_cnt_q != C_TEST)) begin
      testmode_d = 1'b1;
    end
    frame_reset = (lo_cnt_d == C_RESET) && (lo_cnt_q != C_RESET);

    // In test mode (including the entry pulse itself) falls are not counted.
    if (fall && !testmode_q) begin
      frame_active_d = 1'b1;
      if (bit_cnt_q == C_LAST_BIT) begin
        bit_cnt_d = '0;
        if (led_cnt_q == C_LAST_LED) begin
          led_cnt_d = '0;
          if (chan_q != C_CHAN_END) begin
            chan_d = chan_q + 2'd1;
          end
        end else begin
          led_cnt_d = led_cnt_q + 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (frame_reset) begin
      chan_d         = '0;
      led_cnt_d      = '0;
      bit_cnt_d      = '0;
      frame_active_d = 1'b0;
      testmode_d     = 1'b0;
    end

    // chan only moves on a fall cycle, where data_s is low, so no pulse is split.
    broadcast = testmode_q | ~exclusive;
    out_d[0]  = data_s_q & (broadcast | (chan_q == 2'd0));
    out_d[1]  = data_s_q & (broadcast | (chan_q == 2'd1));
    out_d[2]  = data_s_q & (broadcast | (chan_q == 2'd2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= 1'b0;
      data_s_q       <= 1'b0;
      data_p_q       <= 1'b0;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      bit_cnt_q      <= '0;
      led_cnt_q      <= '0;
      chan_q         <= '0;
      frame_active_q <= 1'b0;
      testmode_q     <= 1'b0;
      out_q          <= '0;
    end else begin
      sync1_q        <= sync1_d;
      data_s_q       <= data_s_d;
      data_p_q       <= data_p_d;
      hi_cnt_q       <= hi_cnt_d;
      lo_cnt_q       <= lo_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      led_cnt_q      <= led_cnt_d;
      chan_q         <= chan_d;
      frame_active_q <= frame_active_d;
      testmode_q     <= testmode_d;
      out_q          <= out_d;
    end
  end

  assign out0         = out_q[0];
  assign out1         = out_q[1];
  assign out2         = out_q[2];
  assign testmode     = testmode_q;
  assign chan         = chan_q;
  assign frame_active = frame_active_q;

endmodule

`default_nettype wire

// File: tb/tb_led_chain_router.sv
// +----------------------------------------------------------------------------+
// | tb_led_chain_router                                                        |
// | Directed self-checking bench for led_chain_router (LEDS_PER_CH = 2).       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_led_chain_router;

  localparam int LPC       = 2;
  localparam int BITS_CH   = 24 * LPC;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data = 1'b0;
  logic       exclusive = 1'b1;
  logic       out0, out1, out2;
  logic       testmode;
  logic [1:0] chan;
  logic       frame_active;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] hist = '0;

  led_chain_router #(
    .BIT_THRESH  (30),
    .RESET_CYCLES(2500),
    .TEST_CYCLES (5000),
    .LEDS_PER_CH (LPC),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data        (data),
    .exclusive   (exclusive),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .testmode    (testmode),
    .chan        (chan),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs must equal the pin value of 3 steps ago, masked.
  task automatic step(input logic v, input logic [2:0] m, inout int err);
    @(posedge clk);
    #1 data = v;
    hist = {hist[2:0], v};
    @(negedge clk);
    if ({out2, out1, out0} !== ({3{hist[3]}} & m)) err++;
  endtask

  task automatic send_bit(input logic b, input logic [2:0] m, input string tag);
    int err = 0;
    int nh = b ? 40 : 20;
    int nl = b ? 25 : 45;
    for (int i = 0; i < nh; i++) step(1'b1, m, err);
    for (int i = 0; i < nl; i++) step(1'b0, m, err);
    chk(tag, 32'(err), 32'd0);
  endtask

  task automatic idle(input int n, input logic [2:0] m, input string tag);
    int err = 0;
    for (int i = 0; i < n; i++) step(1'b0, m, err);
    chk(tag, 32'(err), 32'd0);
  endtask

  function automatic logic [2:0] route_mask(input int idx);
    if (idx < BITS_CH)          return 3'b001;
    else if (idx < 2 * BITS_CH) return 3'b010;
    else if (idx < 3 * BITS_CH) return 3'b100;
    else                        return 3'b000;
  endfunction

  function automatic logic pat(input int idx);
    return logic'((idx % 3) == 1);
  endfunction

  initial begin
    int dummy;
    dummy = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset
    idle(3000, 3'b000, "idle_outs");
    chk("rst_outs", {29'd0, out2, out1, out0}, 32'd0);
    chk("rst_chan", 32'(chan), 32'd0);
    chk("rst_testmode", 32'(testmode), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);

    // Exclusive routing across the chain
    for (int i = 0; i < 3 * BITS_CH + 4; i++) begin
      send_bit(pat(i), route_mask(i), $sformatf("excl_bit%0d", i));
      if (i == BITS_CH - 1)     chk("chan_after_48", 32'(chan), 32'd1);
      if (i == 2 * BITS_CH - 1) chk("chan_after_96", 32'(chan), 32'd2);
      if (i == 3 * BITS_CH - 1) chk("chan_after_144", 32'(chan), 32'd3);
    end
    chk("chan_exhausted", 32'(chan), 32'd3);
    chk("frame_active_set", 32'(frame_active), 32'd1);

    // Frame reset restarts at out0
    idle(2600, 3'b000, "gap1_outs");
    chk("gap1_chan", 32'(chan), 32'd0);
    chk("gap1_frame_active", 32'(frame_active), 32'd0);
    send_bit(1'b1, 3'b001, "post_gap_bit");
    chk("post_gap_chan", 32'(chan), 32'd0);
    chk("post_gap_frame_active", 32'(frame_active), 32'd1);

    // Broadcast with exclusive=0, changed only inside a frame-reset gap
    idle(2600, 3'b000, "gap2_outs");
    exclusive = 1'b0;
    for (int i = 0; i < BITS_CH; i++) begin
      send_bit(pat(i + 1), 3'b111, $sformatf("bcast_bit%0d", i));
      if (i == 23) chk("bcast_chan_word1", 32'(chan), 32'd0);
    end
    chk("bcast_chan_word2", 32'(chan), 32'd1);
    idle(2600, 3'b000, "gap3_outs");
    exclusive = 1'b1;
    chk("gap3_chan", 32'(chan), 32'd0);

    // Long high enters test mode (~5003 cycles after the pin rises)
    for (int k = 0; k < 5200; k++) begin
      step(1'b1, 3'b111, dummy);
      if (k == 4900) begin
        chk("pre_test_testmode", 32'(testmode), 32'd0);
        chk("pre_test_out0", 32'(out0), 32'd1);
        chk("pre_test_out1", 32'(out1), 32'd0);
      end
      if (k == 5100) begin
        chk("test_testmode", 32'(testmode), 32'd1);
        chk("test_out1", 32'(out1), 32'd1);
        chk("test_out2", 32'(out2), 32'd1);
      end
    end
    idle(50, 3'b111, "test_tail");
    for (int i = 0; i < 24; i++) send_bit(pat(i), 3'b111, $sformatf("test_bit%0d", i));
    chk("test_chan_frozen", 32'(chan), 32'd0);
    chk("test_still_on", 32'(testmode), 32'd1);
    idle(2600, 3'b000, "gap4_outs");
    chk("test_cleared", 32'(testmode), 32'd0);

    // Reset mid-way through the 30th bit on chan 1
    for (int i = 0; i < BITS_CH + 29; i++) send_bit(pat(i), route_mask(i), $sformatf("pre_rst_bit%0d", i));
    chk("pre_rst_chan", 32'(chan), 32'd1);
    begin
      int err = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 3'b010, err);
      chk("half_bit_out1", 32'(err), 32'd0);
    end
    chk("pre_rst_out1_high", 32'(out1), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    data = 1'b0;
    #1;
    chk("async_rst_chan", 32'(chan), 32'd0);
    chk("async_rst_outs", {29'd0, out2, out1, out0}, 32'd0);
    chk("async_rst_frame_active", 32'(frame_active), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    hist = '0;
    for (int i = 0; i < BITS_CH - 1; i++) send_bit(pat(i), 3'b001, $sformatf("post_rst_bit%0d", i));
    chk("post_rst_chan_47", 32'(chan), 32'd0);
    send_bit(1'b0, 3'b001, "post_rst_bit47");
    chk("post_rst_chan_48", 32'(chan), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
